// File: rtl/amber48_pkg.sv
// amber48 shared types: execute-stage op/result structs, trap causes,
// ALU op codes and the execute-controller state encoding.
package amber48_pkg;

  localparam int XLEN        = 48;
  localparam int BAU_BYTES   = 6;
  localparam int REG_W       = 5;
  localparam int EX_SQUASH_W = 3;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    BR_EQ     = 4'd6,
    BR_NE     = 4'd7,
    BR_LT     = 4'd8,
    ALU_JSUB  = 4'd9,
    ALU_RET   = 4'd10,
    ALU_ECALL = 4'd11
  } amber48_alu_op_e;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_ECALL    = 2'd2,
    TRAP_MISALIGN = 2'd3
  } amber48_trap_cause_e;

  typedef enum logic [1:0] {
    EX_RUN       = 2'd0,
    EX_SQUASH    = 2'd1,
    EX_TRAP_WAIT = 2'd2
  } amber48_ex_state_e;

  typedef struct packed {
    amber48_alu_op_e     op;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic [XLEN-1:0]     imm;
    logic                use_imm;
    logic [REG_W-1:0]    rd;
    amber48_trap_cause_e trap_cause;
  } amber48_execute_in_s;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  result;
  } amber48_execute_out_s;

endpackage

// File: rtl/amber48_alu.sv
// amber48 combinational ALU: arithmetic/logic result, branch resolution
// (taken + target) and trap detection for one decoded op.
module amber48_alu
  import amber48_pkg::*;
(
  input  amber48_execute_in_s  ex_in,
  output amber48_execute_out_s ex_out,
  output logic                 branch_taken,
  output logic [XLEN-1:0]      branch_target,
  output logic                 trap,
  output amber48_trap_cause_e  trap_cause
);

  logic [XLEN-1:0]        rhs;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic signed [XLEN-1:0] rhs_s;

  // Evaluate the op; a trap flagged by decode overrides anything the ALU finds.
  always_comb begin
    rhs           = ex_in.use_imm ? ex_in.imm : ex_in.op_b;
    a_s           = signed'(ex_in.op_a);
    b_s           = signed'(ex_in.op_b);
    rhs_s         = signed'(rhs);
    ex_out.pc     = ex_in.pc;
    ex_out.rd     = ex_in.rd;
    ex_out.result = '0;
    branch_taken  = 1'b0;
    branch_target = ex_in.pc + ex_in.imm;
    trap          = 1'b0;
    trap_cause    = TRAP_NONE;
    case (ex_in.op)
      ALU_ADD:   ex_out.result = ex_in.op_a + rhs;
      ALU_SUB:   ex_out.result = ex_in.op_a - rhs;
      ALU_AND:   ex_out.result = ex_in.op_a & rhs;
      ALU_OR:    ex_out.result = ex_in.op_a | rhs;
      ALU_XOR:   ex_out.result = ex_in.op_a ^ rhs;
      ALU_SLT:   ex_out.result = {{(XLEN-1){1'b0}}, (a_s < rhs_s)};
      BR_EQ:     branch_taken  = (ex_in.op_a == ex_in.op_b);
      BR_NE:     branch_taken  = (ex_in.op_a != ex_in.op_b);
      BR_LT:     branch_taken  = (a_s < b_s);
      ALU_JSUB: begin
        branch_taken  = 1'b1;
        ex_out.result = ex_in.pc + XLEN'(BAU_BYTES);
      end
      ALU_RET: begin
        branch_taken  = 1'b1;
        branch_target = ex_in.op_a;
      end
      ALU_ECALL: begin
        trap       = 1'b1;
        trap_cause = TRAP_ECALL;
      end
      default: ;
    endcase
    if (ex_in.trap_cause != TRAP_NONE) begin
      trap       = 1'b1;
      trap_cause = ex_in.trap_cause;
    end
  end

endmodule

// File: rtl/amber48_ex_ctrl.sv
// amber48 execute-stage controller: decode handshake, EX/MEM register,
// taken-branch redirect with wrong-path squash, and blocking trap handshake.
// Optional AMBER48_EX_PERF_EN adds branch/squash performance counters.
module amber48_ex_ctrl
  import amber48_pkg::*;
#(
  parameter int SQUASH_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  amber48_execute_in_s  id_ex_i,
  input  logic                 flush_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output amber48_execute_out_s mem_ex_o,
  output logic                 redirect_valid_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic                 trap_valid_o,
  output amber48_trap_cause_e  trap_cause_o,
  output logic [XLEN-1:0]      trap_pc_o,
  input  logic                 trap_ack_i
`ifdef AMBER48_EX_PERF_EN
  ,
  output logic [31:0]          perf_branch_cnt_o,
  output logic [31:0]          perf_squash_cnt_o
`endif
);

  localparam logic [EX_SQUASH_W-1:0] SQUASH_LOAD = EX_SQUASH_W'(SQUASH_CYCLES);
  localparam logic [EX_SQUASH_W-1:0] SQUASH_LAST = EX_SQUASH_W'(1);

  amber48_ex_state_e       state_q;
  amber48_ex_state_e       state_d;
  logic [EX_SQUASH_W-1:0]  squash_cnt_q;
  logic [EX_SQUASH_W-1:0]  squash_cnt_d;

  logic                    vld_p1;
  amber48_execute_out_s    mem_ex_p1;

  amber48_execute_out_s    alu_out;
  logic                    alu_taken;
  logic [XLEN-1:0]         alu_target;
  logic                    alu_trap;
  amber48_trap_cause_e     alu_cause;

  logic                    id_ready;
  logic                    accept;
  logic                    exec_fire;
  logic                    load_mem;
  logic                    raise_redirect;
  logic                    raise_trap;
  logic                    drain;

  amber48_alu u_alu (
    .ex_in         (id_ex_i),
    .ex_out        (alu_out),
    .branch_taken  (alu_taken),
    .branch_target (alu_target),
    .trap          (alu_trap),
    .trap_cause    (alu_cause)
  );

  // Handshake decode and next-state/squash-counter selection.
  always_comb begin
    state_d        = state_q;
    squash_cnt_d   = squash_cnt_q;
    id_ready       = 1'b0;
    case (state_q)
      EX_RUN:    id_ready = !vld_p1 || mem_ready_i;
      EX_SQUASH: id_ready = 1'b1;
      default:   id_ready = 1'b0;
    endcase
    accept         = id_valid_i && id_ready;
    exec_fire      = accept && (state_q == EX_RUN) && !flush_i;
    load_mem       = exec_fire && !alu_trap;
    raise_redirect = load_mem && alu_taken;
    raise_trap     = exec_fire && alu_trap;
    drain          = vld_p1 && mem_ready_i;
    case (state_q)
      EX_RUN: begin
        if (raise_trap) begin
          state_d = EX_TRAP_WAIT;
        end else if (raise_redirect) begin
          state_d      = EX_SQUASH;
          squash_cnt_d = SQUASH_LOAD;
        end
      end
      EX_SQUASH: begin
        if (flush_i || squash_cnt_q == SQUASH_LAST) begin
          state_d      = EX_RUN;
          squash_cnt_d = '0;
        end else begin
          squash_cnt_d = squash_cnt_q - 1'b1;
        end
      end
      EX_TRAP_WAIT: begin
        if (trap_ack_i) state_d = EX_RUN;
      end
      default: state_d = EX_RUN;
    endcase
  end

  // State and squash counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EX_RUN;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  // EX/MEM register: flush kills, accept replaces (even while draining), drain empties.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      mem_ex_p1 <= '0;
    end else if (flush_i) begin
      vld_p1    <= 1'b0;
    end else if (load_mem) begin
      vld_p1    <= 1'b1;
      mem_ex_p1 <= alu_out;
    end else if (drain) begin
      vld_p1    <= 1'b0;
    end
  end

  // One-cycle redirect pulse; the target is held until the next redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= raise_redirect;
      if (raise_redirect) redirect_pc_o <= alu_target;
    end
  end

  // Trap capture, held until the trap unit acknowledges it; flush leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_valid_o <= 1'b0;
      trap_cause_o <= TRAP_NONE;
      trap_pc_o    <= '0;
    end else if (raise_trap) begin
      trap_valid_o <= 1'b1;
      trap_cause_o <= alu_cause;
      trap_pc_o    <= id_ex_i.pc;
    end else if (state_q == EX_TRAP_WAIT && trap_ack_i) begin
      trap_valid_o <= 1'b0;
    end
  end

`ifdef AMBER48_EX_PERF_EN
  logic squash_drop;
  assign squash_drop = accept && (state_q == EX_SQUASH);

  // Free-running event counters; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_branch_cnt_o <= '0;
      perf_squash_cnt_o <= '0;
    end else begin
      if (raise_redirect) perf_branch_cnt_o <= perf_branch_cnt_o + 32'd1;
      if (squash_drop)    perf_squash_cnt_o <= perf_squash_cnt_o + 32'd1;
    end
  end
`endif

  assign id_ready_o  = id_ready;
  assign mem_valid_o = vld_p1;
  assign mem_ex_o    = mem_ex_p1;

endmodule

// File: tb/tb_amber48_ex_ctrl.sv
// Scoreboard bench for amber48_ex_ctrl: a cycle-level reference model pushes
// expected EX/MEM results into a queue; a negedge monitor pops on each drain.
module tb_amber48_ex_ctrl;
  import amber48_pkg::*;

  localparam int SQ = 2;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 id_valid_i;
  logic                 id_ready_o;
  amber48_execute_in_s  id_ex_i;
  logic                 flush_i;
  logic                 mem_valid_o;
  logic                 mem_ready_i;
  amber48_execute_out_s mem_ex_o;
  logic                 redirect_valid_o;
  logic [XLEN-1:0]      redirect_pc_o;
  logic                 trap_valid_o;
  amber48_trap_cause_e  trap_cause_o;
  logic [XLEN-1:0]      trap_pc_o;
  logic                 trap_ack_i;
`ifdef AMBER48_EX_PERF_EN
  logic [31:0]          perf_branch_cnt_o;
  logic [31:0]          perf_squash_cnt_o;
`endif

  amber48_ex_ctrl #(.SQUASH_CYCLES(SQ)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_ready_o       (id_ready_o),
    .id_ex_i          (id_ex_i),
    .flush_i          (flush_i),
    .mem_valid_o      (mem_valid_o),
    .mem_ready_i      (mem_ready_i),
    .mem_ex_o         (mem_ex_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .trap_valid_o     (trap_valid_o),
    .trap_cause_o     (trap_cause_o),
    .trap_pc_o        (trap_pc_o),
    .trap_ack_i       (trap_ack_i)
`ifdef AMBER48_EX_PERF_EN
    ,
    .perf_branch_cnt_o(perf_branch_cnt_o),
    .perf_squash_cnt_o(perf_squash_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chkw(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [XLEN-1:0]     res;
    logic                taken;
    logic [XLEN-1:0]     tgt;
    logic                trap;
    amber48_trap_cause_e cause;
  } ref_t;

  function automatic ref_t ref_alu(input amber48_execute_in_s x);
    ref_t r;
    logic [XLEN-1:0] b;
    b = x.use_imm ? x.imm : x.op_b;
    r.res = '0; r.taken = 1'b0; r.tgt = x.pc + x.imm; r.trap = 1'b0; r.cause = TRAP_NONE;
    case (x.op)
      ALU_ADD:   r.res = x.op_a + b;
      ALU_SUB:   r.res = x.op_a - b;
      ALU_AND:   r.res = x.op_a & b;
      ALU_OR:    r.res = x.op_a | b;
      ALU_XOR:   r.res = x.op_a ^ b;
      ALU_SLT:   r.res = ($signed(x.op_a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
      BR_EQ:     r.taken = (x.op_a == x.op_b);
      BR_NE:     r.taken = (x.op_a != x.op_b);
      BR_LT:     r.taken = ($signed(x.op_a) < $signed(x.op_b));
      ALU_JSUB:  begin r.taken = 1'b1; r.res = x.pc + XLEN'(BAU_BYTES); end
      ALU_RET:   begin r.taken = 1'b1; r.tgt = x.op_a; end
      ALU_ECALL: begin r.trap = 1'b1; r.cause = TRAP_ECALL; end
      default: ;
    endcase
    if (x.trap_cause != TRAP_NONE) begin r.trap = 1'b1; r.cause = x.trap_cause; end
    return r;
  endfunction

  bit                   m_full;
  int                   m_sq;
  bit                   m_trap;
  amber48_trap_cause_e  m_cause;
  logic [XLEN-1:0]      m_tpc;
  bit                   m_redir;
  logic [XLEN-1:0]      m_rpc;
  int unsigned          m_pbr;
  int unsigned          m_psq;
  amber48_execute_out_s exp_q[$];

  function automatic void model_reset();
    m_full = 0; m_sq = 0; m_trap = 0; m_cause = TRAP_NONE; m_tpc = '0;
    m_redir = 0; m_rpc = '0; m_pbr = 0; m_psq = 0;
    exp_q.delete();
  endfunction

  function automatic bit model_ready(input bit mr);
    if (m_trap) return 1'b0;
    if (m_sq > 0) return 1'b1;
    return !m_full || mr;
  endfunction

  always @(posedge clk) begin : model
    ref_t r;
    bit acc;
    amber48_execute_out_s e;
    if (rst_i) begin
      model_reset();
    end else begin
      acc = id_valid_i && model_ready(mem_ready_i);
      r = ref_alu(id_ex_i);
      m_redir = 0;
      if (flush_i && m_full && !mem_ready_i && exp_q.size() > 0) void'(exp_q.pop_back());
      if (flush_i || mem_ready_i) m_full = 0;
      if (m_trap) begin
        if (trap_ack_i) m_trap = 0;
      end else if (m_sq > 0) begin
        if (acc) m_psq++;
        m_sq = flush_i ? 0 : m_sq - 1;
      end else if (acc && !flush_i) begin
        if (r.trap) begin
          m_trap = 1; m_cause = r.cause; m_tpc = id_ex_i.pc;
        end else begin
          m_full = 1;
          e.pc = id_ex_i.pc; e.rd = id_ex_i.rd; e.result = r.res;
          exp_q.push_back(e);
          if (r.taken) begin m_redir = 1; m_rpc = r.tgt; m_sq = SQ; m_pbr++; end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    amber48_execute_out_s e;
    if (!rst_i) begin
      chk1("id_ready", id_ready_o, model_ready(mem_ready_i));
      chk1("mem_valid", mem_valid_o, m_full);
      if (mem_valid_o && mem_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_drain: got op pc=0x%0h expected no op at %0t", mem_ex_o.pc, $time);
        end else begin
          e = exp_q.pop_front();
          chkw("mem_result", mem_ex_o.result, e.result);
          chkw("mem_pc", mem_ex_o.pc, e.pc);
          chkw("mem_rd", XLEN'(mem_ex_o.rd), XLEN'(e.rd));
        end
      end
      chk1("redirect_valid", redirect_valid_o, m_redir);
      if (m_redir) chkw("redirect_pc", redirect_pc_o, m_rpc);
      chk1("trap_valid", trap_valid_o, m_trap);
      if (m_trap) begin
        chkw("trap_cause", XLEN'(trap_cause_o), XLEN'(m_cause));
        chkw("trap_pc", trap_pc_o, m_tpc);
      end
`ifdef AMBER48_EX_PERF_EN
      chkw("perf_branch", XLEN'(perf_branch_cnt_o), XLEN'(32'(m_pbr)));
      chkw("perf_squash", XLEN'(perf_squash_cnt_o), XLEN'(32'(m_psq)));
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic amber48_execute_in_s mk(input amber48_alu_op_e op, input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
      input logic ui, input amber48_trap_cause_e tc);
    amber48_execute_in_s x;
    x.op = op; x.pc = pc; x.op_a = a; x.op_b = b; x.imm = imm;
    x.use_imm = ui; x.rd = pc[4:0] ^ a[4:0]; x.trap_cause = tc;
    return x;
  endfunction

  task automatic cycle(input bit v, input amber48_execute_in_s x, input bit mr, input bit fl, input bit ak);
    @(posedge clk); #1;
    id_valid_i = v; id_ex_i = x; mem_ready_i = mr; flush_i = fl; trap_ack_i = ak;
  endtask

  task automatic reset_checks(input string tag);
    chk1({tag, "_id_ready"}, id_ready_o, 1'b1);
    chk1({tag, "_mem_valid"}, mem_valid_o, 1'b0);
    chk1({tag, "_redirect_valid"}, redirect_valid_o, 1'b0);
    chk1({tag, "_trap_valid"}, trap_valid_o, 1'b0);
    chkw({tag, "_mem_result"}, mem_ex_o.result, '0);
    chkw({tag, "_redirect_pc"}, redirect_pc_o, '0);
    chkw({tag, "_trap_pc"}, trap_pc_o, '0);
    chkw({tag, "_trap_cause"}, XLEN'(trap_cause_o), XLEN'(TRAP_NONE));
  endtask

  // Assert reset between clock edges and look at outputs before the next edge.
  task automatic async_reset(input string tag);
    #3;
    id_valid_i = 0; flush_i = 0; trap_ack_i = 0; mem_ready_i = 1;
    rst_i = 1;
    model_reset();
    #1;
    reset_checks(tag);
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  amber48_execute_in_s add53, br, ill, idle_op, rx;

  initial begin
    rst_i = 0; id_valid_i = 0; flush_i = 0; mem_ready_i = 1; trap_ack_i = 0;
    add53   = mk(ALU_ADD, 48'h40, 48'd5, 48'd0, 48'd3, 1'b1, TRAP_NONE);
    br      = mk(BR_EQ, 48'h100, 48'd7, 48'd7, 48'h40, 1'b0, TRAP_NONE);
    ill     = mk(ALU_ADD, 48'h200, 48'd1, 48'd2, 48'd0, 1'b0, TRAP_ILLEGAL);
    idle_op = mk(ALU_XOR, 48'h10, 48'd9, 48'd6, 48'd0, 1'b0, TRAP_NONE);
    id_ex_i = idle_op;
    model_reset();
    #1 rst_i = 1;
    #1 reset_checks("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_i = 0;

    // Back-to-back adds with MEM always ready.
    repeat (4) cycle(1, add53, 1, 0, 0);
    // MEM stalls for 3 cycles with an op waiting, then releases.
    repeat (3) cycle(1, add53, 0, 0, 0);
    cycle(1, add53, 1, 0, 0);
    cycle(0, idle_op, 1, 0, 0);
    // Taken branch; the next two beats fall in the squash window.
    cycle(1, br, 1, 0, 0);
    cycle(1, add53, 1, 0, 0);
    cycle(1, add53, 1, 0, 0);
    cycle(0, idle_op, 1, 0, 0);
    @(negedge clk);
    chkw("branch_target_0x140", redirect_pc_o, 48'h140);
    // Illegal op at 0x200, acknowledged after 4 cycles.
    cycle(1, ill, 1, 0, 0);
    repeat (4) cycle(1, add53, 1, 0, 0);
    cycle(1, add53, 1, 0, 1);
    cycle(0, idle_op, 1, 0, 0);
    @(negedge clk);
    chkw("trap_pc_0x200", trap_pc_o, 48'h200);
    // Flush in the squash window with a beat offered.
    cycle(1, br, 1, 0, 0);
    cycle(1, add53, 1, 1, 0);
    cycle(1, add53, 1, 0, 0);
    cycle(0, idle_op, 1, 0, 0);
    // Flush while a trap is pending.
    cycle(1, ill, 0, 0, 0);
    cycle(1, add53, 0, 1, 0);
    cycle(0, idle_op, 1, 0, 0);
    cycle(0, idle_op, 1, 0, 1);
    cycle(0, idle_op, 1, 0, 0);
    // Reset mid-trap and mid-squash.
    cycle(1, ill, 1, 0, 0);
    cycle(0, idle_op, 1, 0, 0);
    async_reset("rst_mid_trap");
    cycle(1, br, 1, 0, 0);
    cycle(1, add53, 1, 0, 0);
    async_reset("rst_mid_squash");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [XLEN-1:0] a, b;
      amber48_trap_cause_e tc;
      a  = XLEN'($urandom_range(0, 31));
      b  = ($urandom_range(0, 3) == 0) ? a : XLEN'({$urandom(), $urandom()});
      tc = ($urandom_range(0, 99) < 5) ? TRAP_ILLEGAL : TRAP_NONE;
      rx = mk(amber48_alu_op_e'(4'($urandom_range(0, 11))),
              XLEN'({$urandom(), $urandom()}), a, b,
              XLEN'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1), tc);
      cycle($urandom_range(0, 99) < 70, rx, $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 30);
    end
    repeat (4) cycle(0, idle_op, 1, 0, 1);
    repeat (4) cycle(0, idle_op, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amber48_ex_ctrl.md
# amber48_ex_ctrl

Execute-stage controller for the amber48 core. Accepts decoded ops from the decode stage over a valid/ready handshake and evaluates them through one `amber48_alu` instance. Registers the result into the EX/MEM pipeline register. Sequences control-flow side effects: a one-cycle fetch redirect on taken branches/returns, wrong-path squash, and a blocking trap handshake to the trap unit.

## Interface
- `SQUASH_CYCLES`, default 1 — cycles after a redirect during which incoming decode beats are consumed and discarded (1..7).
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `id_valid_i`  in  1  decode offers an op.
- `id_ready_o`  out  1  controller can take an op this cycle.
- `id_ex_i`  in  `amber48_execute_in_s`  decoded op.
- `flush_i`  in  1  flush from a later stage.
- `mem_valid_o`  out  1  EX/MEM register holds a valid op.
- `mem_ready_i`  in  1  MEM stage takes the op.
- `mem_ex_o`  out  `amber48_execute_out_s`  registered ALU output.
- `redirect_valid_o`  out  1  one-cycle fetch redirect pulse.
- `redirect_pc_o`  out  XLEN  redirect target.
- `trap_valid_o`  out  1  trap pending; held until acknowledged.
- `trap_cause_o`  out  `amber48_trap_cause_e`  trap cause.
- `trap_pc_o`  out  XLEN  pc of the trapping op.
- `trap_ack_i`  in  1  trap unit has taken the trap.

## Operation
- States: `EX_RUN`, `EX_SQUASH`, `EX_TRAP_WAIT`.
- `id_ready_o`:
  - `EX_RUN`: `!mem_valid_o || mem_ready_i`.
  - `EX_SQUASH`: 1.
  - `EX_TRAP_WAIT`: 0.
- Accept = `id_valid_i && id_ready_o`. Only `EX_RUN` accepts execute; `EX_SQUASH` accepts are dropped.
- Accepted op without trap:
  - The registered ALU output is loaded into the EX/MEM register with `mem_valid_o=1`.
  - If the ALU's `branch_taken` is set: `redirect_pc_o` = ALU `branch_target`, `redirect_valid_o` pulses, the squash counter loads `SQUASH_CYCLES`, and the state goes to `EX_SQUASH`.
  - The branch/jump-sub op itself still goes to MEM, so the link writeback happens.
- Accepted op with ALU `trap`=1:
  - The op does not enter MEM; `mem_valid_o` follows the normal drain.
  - Load `trap_cause_o` from the ALU and `trap_pc_o` from `id_ex_i.pc`.
  - Set `trap_valid_o`, go to `EX_TRAP_WAIT`. No redirect even if `branch_taken` is set.
- `EX_SQUASH`: the counter decrements every cycle; at 1 → `EX_RUN`.
- `EX_TRAP_WAIT`: on `trap_ack_i`, clear `trap_valid_o` → `EX_RUN`. `trap_ack_i` outside this state is ignored.
- EX/MEM register:
  - Drained when `mem_ready_i && mem_valid_o`.
  - Same-cycle drain and accept replaces the content with no bubble.
  - With no drain, content and `mem_valid_o` are held stable.
- `flush_i` has priority over everything except a pending trap:
  - Clears `mem_valid_o`.
  - Discards any same-cycle accept.
  - Suppresses a redirect being raised that cycle.
  - `EX_SQUASH` → `EX_RUN`.
  - In `EX_TRAP_WAIT` the trap stays pending; `flush_i` only clears `mem_valid_o`.
- Reset mid-operation: all state is discarded immediately, including a pending trap and an in-progress squash.

## Timing
- Reset values:
  - `id_ready_o`: 1, since the state is `EX_RUN` and `mem_valid_o=0`.
  - `mem_valid_o`, `redirect_valid_o`, `trap_valid_o`: 0.
  - `mem_ex_o`, `redirect_pc_o`, `trap_pc_o`: '0.
  - `trap_cause_o`: `TRAP_NONE`.
  - State `EX_RUN`, squash counter 0.
- Accept in cycle N → `mem_valid_o` and `mem_ex_o` valid in N+1.
- Redirect: `redirect_valid_o` high exactly in N+1 for one cycle. Squash covers cycles N+1..N+`SQUASH_CYCLES`; `EX_RUN` is re-entered in N+`SQUASH_CYCLES`+1.
- Trap: `trap_valid_o` high from N+1. Ack in cycle M → `trap_valid_o`=0 and `id_ready_o` may go high in M+1.
- `id_ready_o` is combinational from state, `mem_valid_o` and `mem_ready_i`. There is no path from `id_valid_i` to `id_ready_o`.
- Throughput: 1 op/cycle while MEM is always ready and no control flow is taken.

## Configuration
- `AMBER48_EX_PERF_EN` defined:
  - Adds `perf_branch_cnt_o` (32), counting taken branches/returns that produce a redirect.
  - Adds `perf_squash_cnt_o` (32), counting decode beats dropped in `EX_SQUASH`.
  - Both reset to 0, wrap modulo 2^32, and are not cleared by `flush_i`.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- `amber48_pkg` gains:
  - `amber48_ex_state_e` (`EX_RUN`, `EX_SQUASH`, `EX_TRAP_WAIT`).
  - `EX_SQUASH_W` = 3, the squash counter width.
- It reuses the existing `amber48_execute_in_s`, `amber48_execute_out_s`, `amber48_trap_cause_e`, `XLEN` and `BAU_BYTES`.
- Single sub-module: `amber48_alu`, instantiated combinationally on `id_ex_i`. No further hierarchy.

## Test plan
- Back-to-back ALU_ADD, op_a=5, imm=3, `mem_ready_i`=1 → `mem_ex_o.result`=8 in N+1; next op accepted in N+1; no bubbles.
- Hold `mem_ready_i`=0 for 3 cycles with `mem_valid_o`=1 → `id_ready_o`=0 and `mem_ex_o` unchanged. Release → the held op drains and a new op loads the same cycle.
- BR_EQ, op_a=op_b=7, pc=0x100, imm=0x40, `SQUASH_CYCLES`=2:
  - `redirect_valid_o` pulses for one cycle with `redirect_pc_o`=0x140.
  - The next 2 decode beats are dropped and never reach MEM.
  - With `AMBER48_EX_PERF_EN`: `perf_branch_cnt_o` = 1 and `perf_squash_cnt_o` = 2.
- Op with `trap_cause`=TRAP_ILLEGAL, pc=0x200:
  - `trap_valid_o` held with `trap_pc_o`=0x200; `id_ready_o`=0 and the op is absent from MEM.
  - `trap_ack_i` asserted after 4 cycles → `id_ready_o`=1 next cycle.
- `flush_i` during `EX_SQUASH` with an accept in the same cycle → `mem_valid_o`=0 next cycle, state `EX_RUN`, no redirect. `flush_i` during `EX_TRAP_WAIT` → `trap_valid_o` stays 1.
- Assert `rst_i` asynchronously mid-trap and mid-squash → all outputs return to their reset values before the next clock edge.
